// File: rtl/soma_if.sv
// Operand/result handshake bundle for soma_pipe: the producer/consumer side uses
// the master modport and the arithmetic unit uses the slave modport.
interface soma_if #(
  parameter int W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/soma_pipe.sv
// Pipelined W-bit add/subtract: the carry chain is cut into STAGES chunks, one per register stage.
// Optional macro SOMA_SAT_EN: on signed overflow the last stage saturates s to the signed limit.
module soma_pipe #(
  parameter int W      = 10,
  parameter int STAGES = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  soma_if.slave  bus
);
  localparam int CW = W / STAGES;

  if ((STAGES < 1) || (STAGES > W) || ((W % STAGES) != 0)) begin : g_bad_cfg
    $error("soma_pipe: W must be a multiple of STAGES and 1 <= STAGES <= W");
  end

  logic [W-1:0]      bp0;
  logic              c0;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;

  assign bp0 = bus.op ? ~bus.b : bus.b;
  assign c0  = bus.op | bus.cin;

  // A stage may load unless it and every stage after it is full while the output stalls.
  always_comb begin : p_load
    logic full_run;
    full_run = 1'b1;
    ld       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_run = full_run & vld[k];
      ld[k]    = bus.out_ready | ~full_run;
    end
  end

  assign bus.in_ready = ld[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic                  up_vld;
    logic [W-1:gi*CW]      a_up;
    logic [W-1:gi*CW]      bp_up;
    logic                  c_up;
    logic [CW:0]           chunk;
    logic [(gi+1)*CW-1:0]  sum_next;
    logic [(gi+1)*CW-1:0]  sum_d;
    logic [(gi+1)*CW-1:0]  sum_r;
    logic                  c_r;
    logic                  vld_r;

    if (gi == 0) begin : g_first
      assign up_vld   = bus.in_valid;
      assign a_up     = bus.a;
      assign bp_up    = bp0;
      assign c_up     = c0;
      assign sum_next = chunk[CW-1:0];
    end else begin : g_rest
      assign up_vld   = g_stage[gi-1].vld_r;
      assign a_up     = g_stage[gi-1].g_fwd.a_r;
      assign bp_up    = g_stage[gi-1].g_fwd.bp_r;
      assign c_up     = g_stage[gi-1].c_r;
      assign sum_next = {chunk[CW-1:0], g_stage[gi-1].sum_r};
    end

    assign chunk = {1'b0, a_up[gi*CW +: CW]} + {1'b0, bp_up[gi*CW +: CW]}
                 + {{CW{1'b0}}, c_up};

    // Only the operand chunks still to be summed travel on to later stages.
    if (gi < STAGES - 1) begin : g_fwd
      logic [W-1:(gi+1)*CW] a_r;
      logic [W-1:(gi+1)*CW] bp_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r  <= '0;
          bp_r <= '0;
        end else if (ld[gi] && up_vld) begin
          a_r  <= a_up[W-1:(gi+1)*CW];
          bp_r <= bp_up[W-1:(gi+1)*CW];
        end
      end

      assign sum_d = sum_next;
    end else begin : g_last
      logic ovf_next;
      logic ovf_r;

      // Overflow: both operands share a sign that the result does not.
      assign ovf_next = (a_up[W-1] ~^ bp_up[W-1]) & (sum_next[W-1] ^ a_up[W-1]);

`ifdef SOMA_SAT_EN
      assign sum_d = !ovf_next ? sum_next
                   : (a_up[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
      assign sum_d = sum_next;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (ld[gi] && up_vld) begin
          ovf_r <= ovf_next;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (ld[gi]) begin
        vld_r <= up_vld;
        if (up_vld) begin
          c_r   <= chunk[CW];
          sum_r <= sum_d;
        end
      end
    end

    assign vld[gi] = vld_r;
  end

  assign bus.out_valid = vld[STAGES-1];
  assign bus.s         = g_stage[STAGES-1].sum_r;
  assign bus.cout      = g_stage[STAGES-1].c_r;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_r;
endmodule
